multimode_register: RTL

//  Parametrised successor to the single-bit D flip-flop: a WIDTH-bit clocked register.

---
 rtl/multimode_register.sv | 96 +++++++++
 1 files changed

// File: rtl/multimode_register.sv
// WIDTH-bit clocked register with hold, load, increment, decrement, shifts and clear.
// A registered carry/borrow/shift-out flag sits alongside q; zero is decoded combinationally from q.
module multimode_register #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_INC   = 3'b010,
    MODE_DEC   = 3'b011,
    MODE_SHL   = 3'b100,
    MODE_SHR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] next_q;
  logic             next_carry;

  // Mode decode only runs when enabled, so an undriven mode during hold cannot leak into state.
  always_comb begin
    next_q     = q;
    next_carry = carry;
    if (enable) begin
      case (mode_t'(mode))
        MODE_LOAD: begin
          next_q     = d;
          next_carry = 1'b0;
        end
        MODE_INC: begin
          if (q == ALL_ONES) begin
            next_q     = SATURATE ? ALL_ONES : '0;
            next_carry = 1'b1;
          end else begin
            next_q     = q + ONE;
            next_carry = 1'b0;
          end
        end
        MODE_DEC: begin
          if (q == '0) begin
            next_q     = SATURATE ? '0 : ALL_ONES;
            next_carry = 1'b1;
          end else begin
            next_q     = q - ONE;
            next_carry = 1'b0;
          end
        end
        MODE_SHL: begin
          next_q     = {q[WIDTH-2:0], serial_in};
          next_carry = q[WIDTH-1];
        end
        MODE_SHR: begin
          next_q     = {serial_in, q[WIDTH-1:1]};
          next_carry = q[0];
        end
        MODE_CLEAR: begin
          next_q     = '0;
          next_carry = 1'b0;
        end
        default: begin
          next_q     = q;
          next_carry = carry;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= RESET_VALUE;
      carry <= 1'b0;
    end else begin
      q     <= next_q;
      carry <= next_carry;
    end
  end

  assign zero = (q == '0);

endmodule
